// File: rtl/seq_ctrl_pkg.sv
// Shared types and sizing defaults for the programmable sequence detector.
package seq_ctrl_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // cfg_len must be able to hold MAX_LEN itself, not just MAX_LEN-1.
   function automatic int len_w(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and variable-length masked compare for the
// overlapping Mealy detector.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               run,
   input  logic               x,
   input  logic               x_valid,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               z
);

   logic [MAX_LEN-2:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] mask;
   logic               fill_ok;
   logic               eq;

   // Incoming bit completes the window; it is the LSB of the candidate.
   assign cand = {hist, x};

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len));
   end

   assign fill_ok = (fill >= (len - LEN_W'(1)));
   assign eq      = (((cand ^ pattern) & mask) == '0);
   assign z       = run & x_valid & fill_ok & eq;

   // History is never cleared on a match, so overlapping hits fall out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (run && x_valid) begin
         hist <= cand[MAX_LEN-2:0];
         if (fill != LEN_W'(MAX_LEN))
            fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable sequence detector: config registers,
// IDLE/RUN/DONE sequencing and the match counter.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               start,
   input  logic               abort,
   input  logic               x,
   input  logic               x_valid,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               err_q;
   logic               in_idle;
   logic               in_run;
   logic               go;
   logic               len_ok;
   logic               hit;
   logic               z_core;

   assign in_idle = (state_q == IDLE);
   assign in_run  = (state_q == RUN);
   assign go      = in_idle & start & ~abort & ~err_q;
   assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   // abort beats a same-cycle match for counting, but z still shows it.
   assign hit     = z_core & ~abort;
   assign cnt_inc = cnt_q + 1'b1;

   seq_match_core #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .clr     (go),
      .run     (in_run),
      .x       (x),
      .x_valid (x_valid),
      .pattern (pat_q),
      .len     (len_q),
      .z       (z_core)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (go) state_d = RUN;
         RUN: begin
            if (abort)
               state_d = IDLE;
            else if (hit && (tgt_q != '0) && (cnt_inc == tgt_q))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Illegal lengths flag an error but leave the last good config in place.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q <= '0;
         len_q <= LEN_W'(1);
         tgt_q <= '0;
         err_q <= 1'b0;
      end else if (in_idle && cfg_we) begin
         if (len_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            tgt_q <= cfg_target;
            err_q <= 1'b0;
         end else begin
            err_q <= 1'b1;
         end
      end
   end

   // Free-running runs (target 0) saturate instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (go)
         cnt_q <= '0;
      else if (hit && !((tgt_q == '0) && (cnt_q == '1)))
         cnt_q <= cnt_inc;
   end

   assign z         = z_core;
   assign match_cnt = cnt_q;
   assign busy      = in_run;
   assign done      = (state_q == DONE);
   assign cfg_err   = err_q;

endmodule
